// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Arbitrates result broadcasts from two producers (ALU and LSB) onto a single
// common data bus. Each producer has a private 2-entry FIFO that absorbs results
// which lose arbitration. Under contention the grant alternates between the two
// sources. A request that reaches an empty FIFO and wins the same cycle goes
// straight to the bus, giving one-cycle latency.
//
// Ports
//   clk                      : single clock, all state changes on the rising edge
//   reset                    : synchronous, active-high; highest priority
//   ready                    : global enable; 0 freezes all state and outputs
//   clear                    : synchronous flush (misprediction), below reset
//   alu_in_flag/val/robpos   : ALU result request
//   lsb_in_flag/val/robpos   : LSB result request
//   alu_full, lsb_full       : registered backpressure, high when FIFO holds 2
//   cdb_flag/val/robpos/src  : registered broadcast (src 0 = ALU, 1 = LSB)
//   overflow                 : sticky, set when a request into a full FIFO drops
// -----------------------------------------------------------------------------
module cdb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        clear,
  input  logic        alu_in_flag,
  input  logic [31:0] alu_val,
  input  logic [3:0]  alu_robpos,
  input  logic        lsb_in_flag,
  input  logic [31:0] lsb_val,
  input  logic [3:0]  lsb_robpos,
  output logic        alu_full,
  output logic        lsb_full,
  output logic        cdb_flag,
  output logic [31:0] cdb_val,
  output logic [3:0]  cdb_robpos,
  output logic        cdb_src,
  output logic        overflow
);

  typedef struct packed {
    logic [31:0] val;
    logic [3:0]  robpos;
  } entry_t;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  // Per-source state, indexed by source (0 = ALU, 1 = LSB).
  entry_t     mem     [2][2];   // [source][slot]
  logic       head    [2];
  logic       tail    [2];
  logic [1:0] count   [2];
  logic       full_q  [2];
  logic       last_grant;

  // Combinational view of the current cycle.
  logic       in_flag    [2];
  entry_t     in_entry   [2];
  logic       cand_valid [2];
  entry_t     cand       [2];
  logic       granted    [2];
  logic       pop        [2];
  logic       push       [2];
  logic       drop       [2];
  logic [1:0] count_nxt  [2];
  logic       grant_valid;
  logic       grant_src;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    in_flag     = '{default: 1'b0};
    in_entry    = '{default: '0};
    cand_valid  = '{default: 1'b0};
    cand        = '{default: '0};
    granted     = '{default: 1'b0};
    pop         = '{default: 1'b0};
    push        = '{default: 1'b0};
    drop        = '{default: 1'b0};
    count_nxt   = count;
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;

    in_flag[0]  = alu_in_flag;
    in_flag[1]  = lsb_in_flag;
    in_entry[0] = '{val: alu_val, robpos: alu_robpos};
    in_entry[1] = '{val: lsb_val, robpos: lsb_robpos};

    // A buffered result always outranks a fresh request from the same source,
    // which keeps each source's results in order.
    for (int s = 0; s < 2; s++) begin
      cand_valid[s] = (count[s] != 2'd0) || in_flag[s];
      cand[s]       = (count[s] != 2'd0) ? mem[s][head[s]] : in_entry[s];
    end

    grant_valid = cand_valid[0] || cand_valid[1];
    grant_src   = (cand_valid[0] && cand_valid[1]) ? ~last_grant : cand_valid[1];
    granted[0]  = grant_valid && (grant_src == SRC_ALU);
    granted[1]  = grant_valid && (grant_src == SRC_LSB);

    for (int s = 0; s < 2; s++) begin
      pop[s]  = granted[s] && (count[s] != 2'd0);
      // A granted request into an empty FIFO bypasses storage entirely; a
      // full FIFO still accepts a push when its head leaves this same cycle.
      push[s] = in_flag[s] && !(granted[s] && (count[s] == 2'd0)) &&
                ((count[s] != 2'd2) || pop[s]);
      drop[s] = in_flag[s] && (count[s] == 2'd2) && !pop[s];
      if (push[s] && !pop[s])
        count_nxt[s] = count[s] + 2'd1;
      else if (pop[s] && !push[s])
        count_nxt[s] = count[s] - 2'd1;
    end
  end

  // Control state and registered outputs. Priority: reset > clear > ready.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        count[s]  <= 2'd0;
        head[s]   <= 1'b0;
        tail[s]   <= 1'b0;
        full_q[s] <= 1'b0;
      end
      cdb_flag   <= 1'b0;
      cdb_val    <= 32'd0;
      cdb_robpos <= 4'd0;
      cdb_src    <= SRC_ALU;
      overflow   <= 1'b0;
      last_grant <= SRC_LSB;   // so the ALU wins the first tie
    end else if (clear) begin
      // Flush drops this cycle's requests; fairness and the sticky error
      // flag survive the flush, and cdb_val/robpos/src simply hold.
      for (int s = 0; s < 2; s++) begin
        count[s]  <= 2'd0;
        head[s]   <= 1'b0;
        tail[s]   <= 1'b0;
        full_q[s] <= 1'b0;
      end
      cdb_flag <= 1'b0;
    end else if (ready) begin
      for (int s = 0; s < 2; s++) begin
        count[s]  <= count_nxt[s];
        full_q[s] <= (count_nxt[s] == 2'd2);
        if (pop[s])  head[s] <= ~head[s];
        if (push[s]) tail[s] <= ~tail[s];
      end
      if (grant_valid) begin
        cdb_flag   <= 1'b1;
        cdb_val    <= cand[grant_src].val;
        cdb_robpos <= cand[grant_src].robpos;
        cdb_src    <= grant_src;
        last_grant <= grant_src;
      end else begin
        cdb_flag <= 1'b0;
      end
      overflow <= overflow || drop[0] || drop[1];
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count gates every read, so
  // stale slot contents are never observable.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!reset && !clear && ready && push[s])
        mem[s][tail[s]] <= in_entry[s];
    end
  end

  assign alu_full = full_q[0];
  assign lsb_full = full_q[1];

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. Inputs change 1 ns after a rising edge and
// outputs are compared at that same point, i.e. they show the result of the
// edge just taken. Expected values are hand-derived from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        clear;
  logic        alu_in_flag;
  logic [31:0] alu_val;
  logic [3:0]  alu_robpos;
  logic        lsb_in_flag;
  logic [31:0] lsb_val;
  logic [3:0]  lsb_robpos;
  logic        alu_full;
  logic        lsb_full;
  logic        cdb_flag;
  logic [31:0] cdb_val;
  logic [3:0]  cdb_robpos;
  logic        cdb_src;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .clear       (clear),
    .alu_in_flag (alu_in_flag),
    .alu_val     (alu_val),
    .alu_robpos  (alu_robpos),
    .lsb_in_flag (lsb_in_flag),
    .lsb_val     (lsb_val),
    .lsb_robpos  (lsb_robpos),
    .alu_full    (alu_full),
    .lsb_full    (lsb_full),
    .cdb_flag    (cdb_flag),
    .cdb_val     (cdb_val),
    .cdb_robpos  (cdb_robpos),
    .cdb_src     (cdb_src),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Bus packed as {flag, src, robpos, val}.
  logic [37:0] cdb_obs;
  assign cdb_obs = {cdb_flag, cdb_src, cdb_robpos, cdb_val};

  function automatic logic [37:0] cdb_exp(input logic f, input logic s,
                                          input logic [3:0] r, input logic [31:0] v);
    return {f, s, r, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic af, input logic [31:0] av, input logic [3:0] ar,
                       input logic lf, input logic [31:0] lv, input logic [3:0] lr);
    alu_in_flag = af;
    alu_val     = av;
    alu_robpos  = ar;
    lsb_in_flag = lf;
    lsb_val     = lv;
    lsb_robpos  = lr;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
  endtask

  // Reset with live requests on the inputs; they must be ignored.
  task automatic apply_reset();
    reset = 1'b1;
    drive(1'b1, 32'hDEAD, 4'hF, 1'b1, 32'hBEEF, 4'hE);
    tick();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_reset();
    ready = 1'b1;
    clear = 1'b0;
    apply_reset();
    n_checks++;
    if (cdb_obs !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_cdb: got %h want %h", cdb_obs, 38'd0);
    end
    n_checks++;
    if ({alu_full, lsb_full, overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {alu_full, lsb_full, overflow});
    end
    tick();
    n_checks++;
    if (cdb_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_bcast: got %b want 0", cdb_flag);
    end
  endtask

  task automatic test_single();
    apply_reset();
    drive(1'b1, 32'h11, 4'd3, 1'b0, 32'h0, 4'h0);
    tick();
    idle();
    n_checks++;
    if (cdb_obs !== cdb_exp(1'b1, 1'b0, 4'd3, 32'h11)) begin
      n_fail++;
      $display("FAIL single_bcast: got %h want %h", cdb_obs, cdb_exp(1'b1, 1'b0, 4'd3, 32'h11));
    end
    tick();
    n_checks++;
    if (cdb_obs !== cdb_exp(1'b0, 1'b0, 4'd3, 32'h11)) begin
      n_fail++;
      $display("FAIL single_idle: got %h want %h", cdb_obs, cdb_exp(1'b0, 1'b0, 4'd3, 32'h11));
    end
  endtask

  task automatic test_tie();
    logic [37:0] exp_seq [3];
    exp_seq[0] = cdb_exp(1'b1, 1'b0, 4'd1, 32'hA);
    exp_seq[1] = cdb_exp(1'b1, 1'b1, 4'd2, 32'hB);
    exp_seq[2] = cdb_exp(1'b0, 1'b1, 4'd2, 32'hB);
    apply_reset();
    drive(1'b1, 32'hA, 4'd1, 1'b1, 32'hB, 4'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      idle();
      n_checks++;
      if (cdb_obs !== exp_seq[c]) begin
        n_fail++;
        $display("FAIL tie_cycle%0d: got %h want %h", c, cdb_obs, exp_seq[c]);
      end
    end
  endtask

  // Both producers request every cycle they are allowed to (not full).
  // Under contention grants alternate, so bus item k is source k%2, item k/2.
  task automatic test_back_to_back();
    int ai = 0;
    int bi = 0;
    logic [37:0] exp_w;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      drive(!alu_full, 32'hA0 + ai, 4'(ai), !lsb_full, 32'hB0 + bi, 4'(8 + bi));
      if (!alu_full) ai++;
      if (!lsb_full) bi++;
      tick();
      exp_w = (k % 2 == 0) ? cdb_exp(1'b1, 1'b0, 4'(k / 2), 32'hA0 + k / 2)
                           : cdb_exp(1'b1, 1'b1, 4'(8 + k / 2), 32'hB0 + k / 2);
      n_checks++;
      if (cdb_obs !== exp_w) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got %h want %h", k, cdb_obs, exp_w);
      end
      n_checks++;
      if (overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_overflow%0d: got %b want 0", k, overflow);
      end
    end
    idle();
  endtask

  // Requests every cycle ignoring backpressure. The LSB FIFO fills while the
  // ALU wins, stays full through an LSB grant with refill, and the LSB request
  // in cycle 4 (0xD4, rob 12) meets a full FIFO on an ALU-won cycle: dropped.
  task automatic test_overflow();
    logic [37:0] exp_w;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      drive(c < 4, 32'hC0 + c, 4'(c), c < 5, 32'hD0 + c, 4'(8 + c));
      tick();
      if (c < 8)
        exp_w = (c % 2 == 0) ? cdb_exp(1'b1, 1'b0, 4'(c / 2), 32'hC0 + c / 2)
                             : cdb_exp(1'b1, 1'b1, 4'(8 + c / 2), 32'hD0 + c / 2);
      else
        exp_w = cdb_exp(1'b0, 1'b1, 4'd11, 32'hD3);
      n_checks++;
      if (cdb_obs !== exp_w) begin
        n_fail++;
        $display("FAIL ovf_cycle%0d: got %h want %h", c, cdb_obs, exp_w);
      end
      n_checks++;
      if (overflow !== (c >= 4)) begin
        n_fail++;
        $display("FAIL ovf_flag%0d: got %b want %b", c, overflow, c >= 4);
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if ({alu_full, lsb_full} !== ((c == 3) ? 2'b11 : 2'b01)) begin
          n_fail++;
          $display("FAIL ovf_full%0d: got %b want %b", c, {alu_full, lsb_full},
                   (c == 3) ? 2'b11 : 2'b01);
        end
      end
    end
    idle();
  endtask

  // ALU holds 0x12, LSB holds 0x21,0x22 when ready drops; bus shows 0x11.
  task automatic test_ready_hold();
    logic [37:0] held;
    logic [37:0] drain [4];
    held     = cdb_exp(1'b1, 1'b0, 4'd1, 32'h11);
    drain[0] = cdb_exp(1'b1, 1'b1, 4'd5, 32'h21);
    drain[1] = cdb_exp(1'b1, 1'b0, 4'd2, 32'h12);
    drain[2] = cdb_exp(1'b1, 1'b1, 4'd6, 32'h22);
    drain[3] = cdb_exp(1'b0, 1'b1, 4'd6, 32'h22);
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h10 + c, 4'(c), 1'b1, 32'h20 + c, 4'(4 + c));
      tick();
    end
    ready = 1'b0;
    drive(1'b1, 32'hEE, 4'hE, 1'b1, 32'hEF, 4'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (cdb_obs !== held) begin
        n_fail++;
        $display("FAIL hold_cdb%0d: got %h want %h", c, cdb_obs, held);
      end
      n_checks++;
      if ({alu_full, lsb_full, overflow} !== 3'b010) begin
        n_fail++;
        $display("FAIL hold_flags%0d: got %b want 010", c, {alu_full, lsb_full, overflow});
      end
    end
    ready = 1'b1;
    idle();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (cdb_obs !== drain[c]) begin
        n_fail++;
        $display("FAIL hold_drain%0d: got %h want %h", c, cdb_obs, drain[c]);
      end
    end
  endtask

  // Both FIFOs full (last grant ALU, overflow set), then clear, then a
  // mid-drain reset.
  task automatic test_clear_and_reset();
    logic [37:0] exp_w;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h30 + c, 4'(c), 1'b1, 32'h40 + c, 4'(8 + c));
      tick();
      exp_w = (c % 2 == 0) ? cdb_exp(1'b1, 1'b0, 4'(c / 2), 32'h30 + c / 2)
                           : cdb_exp(1'b1, 1'b1, 4'(8 + c / 2), 32'h40 + c / 2);
      n_checks++;
      if (cdb_obs !== exp_w) begin
        n_fail++;
        $display("FAIL clr_fill%0d: got %h want %h", c, cdb_obs, exp_w);
      end
    end
    n_checks++;
    if ({alu_full, lsb_full, overflow} !== 3'b111) begin
      n_fail++;
      $display("FAIL clr_prefull: got %b want 111", {alu_full, lsb_full, overflow});
    end
    clear = 1'b1;
    drive(1'b1, 32'h77, 4'hF, 1'b1, 32'h78, 4'hF);
    tick();
    clear = 1'b0;
    idle();
    n_checks++;
    if ({cdb_flag, alu_full, lsb_full, overflow} !== 4'b0001) begin
      n_fail++;
      $display("FAIL clr_after: got %b want 0001", {cdb_flag, alu_full, lsb_full, overflow});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (cdb_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_stale%0d: got flag %b rob %h want flag 0", c, cdb_flag, cdb_robpos);
      end
    end
    // Last grant before the flush was ALU, so the LSB wins this tie.
    drive(1'b1, 32'h55, 4'd5, 1'b1, 32'h66, 4'd6);
    tick();
    idle();
    n_checks++;
    if (cdb_obs !== cdb_exp(1'b1, 1'b1, 4'd6, 32'h66)) begin
      n_fail++;
      $display("FAIL clr_fair: got %h want %h", cdb_obs, cdb_exp(1'b1, 1'b1, 4'd6, 32'h66));
    end
    // ALU 0x55 is still buffered; reset now must discard it.
    apply_reset();
    n_checks++;
    if ({cdb_obs, alu_full, lsb_full, overflow} !== 41'd0) begin
      n_fail++;
      $display("FAIL midreset: got %h want 0", {cdb_obs, alu_full, lsb_full, overflow});
    end
    tick();
    n_checks++;
    if (cdb_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_drain: got flag %b val %h want flag 0", cdb_flag, cdb_val);
    end
    drive(1'b1, 32'h5A, 4'd1, 1'b1, 32'h6A, 4'd2);
    tick();
    idle();
    n_checks++;
    if (cdb_obs !== cdb_exp(1'b1, 1'b0, 4'd1, 32'h5A)) begin
      n_fail++;
      $display("FAIL midreset_tie: got %h want %h", cdb_obs, cdb_exp(1'b1, 1'b0, 4'd1, 32'h5A));
    end
    tick();
    n_checks++;
    if (cdb_obs !== cdb_exp(1'b1, 1'b1, 4'd2, 32'h6A)) begin
      n_fail++;
      $display("FAIL midreset_tie2: got %h want %h", cdb_obs, cdb_exp(1'b1, 1'b1, 4'd2, 32'h6A));
    end
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b1;
    clear = 1'b0;
    idle();
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_overflow();
    test_ready_hold();
    test_clear_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have ports: clk input 1, single clock; all state changes on rising edge.
REQ-002 SHALL have reset input 1; synchronous, active-high.
REQ-003 SHALL have ready input 1; global enable: 0 = hold all state and outputs, ignore inputs.
REQ-004 SHALL have clear input 1; synchronous pipeline flush from misprediction.
REQ-005 SHALL have alu_in_flag input 1, alu_val input 32, alu_robpos input 4; ALU result request.
REQ-006 SHALL have lsb_in_flag input 1, lsb_val input 32, lsb_robpos input 4; LSB result request.
REQ-007 SHALL have alu_full output 1 and lsb_full output 1; per-source backpressure.
REQ-008 SHALL have cdb_flag output 1, cdb_val output 32, cdb_robpos output 4 and cdb_src output 1; registered broadcast, where cdb_src 0 = ALU and 1 = LSB.
REQ-009 SHALL have overflow output 1; sticky protocol-violation flag.

Function
REQ-010 SHALL keep one 2-entry FIFO (val, robpos) per source, with count 0..2 and wrap-around head/tail pointers.
REQ-011 SHALL define the candidate of a source as its FIFO head if count>0, else the incoming request if in_flag=1, else none.
REQ-012 SHALL grant at most one candidate per cycle; single candidate -> granted.
REQ-013 SHALL, when both candidates are valid, grant the source != last_grant, then set last_grant to the granted source.
REQ-014 SHALL update last_grant only on a grant; an idle cycle leaves it unchanged.
REQ-015 SHALL, on the next edge after a grant, present cdb_flag=1 with the candidate's val/robpos/src; with no grant, cdb_flag=0 and val/robpos/src hold their previous values.
REQ-016 SHALL give one-cycle latency: a request arriving to an empty FIFO and granted bypasses the FIFO and appears on the CDB at the next edge.
REQ-017 SHALL pop the FIFO head when that source is granted from its FIFO.
REQ-018 SHALL push a non-bypassed incoming request into its FIFO at the tail.
REQ-019 SHALL allow a simultaneous pop and push on one source: count unchanged, order preserved.
REQ-020 SHALL set x_full = (count==2), registered; the producer must not assert in_flag while full.
REQ-021 SHALL, on in_flag while count==2 and no pop that cycle, drop the request and set overflow=1; with a pop in that cycle, the push is accepted.
REQ-022 SHALL, when ready=0, change no state and no output, including FIFOs, last_grant, cdb_* and overflow.
REQ-023 SHALL give priority reset > clear > ready.
REQ-024 SHALL, on clear, empty both FIFOs, set cdb_flag=0 and full=0, and drop the inputs of that cycle; last_grant and overflow are kept.

Reset
REQ-025 SHALL, on reset, set count=0 for both FIFOs, cdb_flag=0, cdb_val=0, cdb_robpos=0, cdb_src=0, alu_full=0, lsb_full=0, overflow=0 and last_grant=1 (ALU wins first tie).
REQ-026 SHALL apply reset in any state, including mid-drain, with the same result as REQ-025; inputs in a reset cycle are ignored.

Verification
REQ-027 Bench SHALL cover: single ALU request val=0x11 rob=3 -> next cycle cdb_flag=1, val=0x11, rob=3, src=0; following cycle cdb_flag=0.
REQ-028 Bench SHALL cover: after reset, ALU (0xA, rob 1) and LSB (0xB, rob 2) in the same cycle -> cycle+1 ALU/rob1, cycle+2 LSB/rob2, no bubble.
REQ-029 Bench SHALL cover: both sources request every cycle for 6 cycles -> strict alternation ALU,LSB,ALU,...; lsb_full never rises above count 2; overflow stays 0.
REQ-030 Bench SHALL cover: fill LSB FIFO to 2 while ALU wins, then LSB asserts in_flag while lsb_full=1 and is not granted -> overflow=1, dropped value never broadcast.
REQ-031 Bench SHALL cover: ready=0 for 3 cycles with both FIFOs non-empty -> cdb_* frozen at the last value and counts unchanged; after ready=1, drain resumes in the same order.
REQ-032 Bench SHALL cover: clear with both FIFOs full -> next cycle cdb_flag=0, both full=0, and no stale robpos is ever broadcast afterward.
